// File: rtl/isa_pkg.sv
// Shared fetch-path definitions: default widths, sequential PC step and the
// fetch FSM state encoding.
package isa_pkg;

   localparam int ADDR_W_DEFAULT  = 16;
   localparam int DATA_W_DEFAULT  = 16;
   localparam int PC_STEP_DEFAULT = 1;

   // Fetch FSM: issue a read, wait for its data, hold it for decode.
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: reads imem at pc_cur, computes the next PC and its
// load enable, and hands the fetched word to decode through a one-entry
// valid/ready buffer. Branch redirects flush in-flight and buffered fetches.
module fetch_unit
   import isa_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEFAULT,
   parameter int DATA_W  = DATA_W_DEFAULT,
   parameter int PC_STEP = PC_STEP_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic [ADDR_W-1:0] pc_next,
   output logic              pc_en,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   input  logic              id_ready
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   fetch_state_t      state, state_nxt;
   logic              drop, drop_nxt;         // outstanding read is stale
   logic [ADDR_W-1:0] req_addr, req_addr_nxt; // address of outstanding read
   logic              if_valid_nxt;
   logic [DATA_W-1:0] if_instr_nxt;
   logic [ADDR_W-1:0] if_pc_nxt;

   // Next-state, memory request, PC update and output-buffer next values.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned; that is what keeps this block free of inferred latches.
      state_nxt    = state;
      drop_nxt     = drop;
      req_addr_nxt = req_addr;
      if_valid_nxt = if_valid;
      if_instr_nxt = if_instr;
      if_pc_nxt    = if_pc;
      imem_req     = 1'b0;
      imem_addr    = pc_cur;
      pc_next      = pc_cur;
      pc_en        = 1'b0;

      if (!reset_n) begin
         // Keep the PC and memory quiet while the block is held in reset.
         pc_next = '0;
      end else begin
         // A redirect wins over everything else, including a same-cycle ack.
         if (br_taken) begin
            pc_next      = br_target;
            pc_en        = 1'b1;
            if_valid_nxt = 1'b0;
         end

         case (state)
            S_REQ: begin
               if (!br_taken) begin
                  imem_req     = 1'b1;
                  req_addr_nxt = pc_cur;
                  state_nxt    = S_WAIT;
               end
            end

            S_WAIT: begin
               if (imem_ack) begin
                  drop_nxt = 1'b0;
                  if (br_taken || drop) begin
                     // Data belongs to a flushed fetch: discard and refetch.
                     state_nxt = S_REQ;
                  end else begin
                     if_instr_nxt = imem_rdata;
                     if_pc_nxt    = req_addr;
                     if_valid_nxt = 1'b1;
                     pc_next      = req_addr + STEP;
                     pc_en        = 1'b1;
                     state_nxt    = S_HOLD;
                  end
               end else if (br_taken) begin
                  // Read still in flight; remember to throw its data away.
                  drop_nxt = 1'b1;
               end
            end

            S_HOLD: begin
               // A redirect also cancels a concurrent id_ready handshake.
               if (br_taken || id_ready) begin
                  if_valid_nxt = 1'b0;
                  state_nxt    = S_REQ;
               end
            end

            default: state_nxt = S_REQ;
         endcase
      end
   end

   // State, drop flag, request address and output buffer registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!reset_n) begin
         state    <= S_REQ;
         drop     <= 1'b0;
         req_addr <= '0;
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
      end else begin
         state    <= state_nxt;
         drop     <= drop_nxt;
         req_addr <= req_addr_nxt;
         if_valid <= if_valid_nxt;
         if_instr <= if_instr_nxt;
         if_pc    <= if_pc_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: models the PC register and a fixed-latency
// instruction memory returning 0x1000+addr, and scoreboards every fetch from
// request to decode transfer.
module tb_fetch_unit;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } fetch_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] pc_cur;
   logic [15:0] pc_next;
   logic        pc_en;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        br_taken;
   logic [15:0] br_target;
   logic        if_valid;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic        id_ready;

   int          n_vec = 0;
   int          n_bad = 0;
   int          n_req = 0;
   int          n_pcen = 0;
   int          n_ack = 0;
   int          n_xfer = 0;
   int          lat = 1;
   int          mem_cnt = 0;
   logic [15:0] mem_addr = '0;
   logic [15:0] exp_pc = '0;
   fetch_t      sb[$];

   // Values sampled at the falling edge of the most recent tick.
   logic        s_req, s_en, s_ack, s_valid;
   logic [15:0] s_addr, s_next, s_pc, s_instr;

   fetch_unit dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pc_cur    (pc_cur),
      .pc_next   (pc_next),
      .pc_en     (pc_en),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_rdata(imem_rdata),
      .br_taken  (br_taken),
      .br_target (br_target),
      .if_valid  (if_valid),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .id_ready  (id_ready)
   );

   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at negedge, scoreboard, then update PC and memory models.
   task automatic tick();
      logic br_s, rdy_s, rst_s;
      fetch_t e;
      @(negedge clk);
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_en    = pc_en;
      s_next  = pc_next;
      s_ack   = imem_ack;
      s_valid = if_valid;
      s_pc    = if_pc;
      s_instr = if_instr;
      br_s    = br_taken;
      rdy_s   = id_ready;
      rst_s   = reset_n;

      if (!rst_s) begin
         sb.delete();
         exp_pc = '0;
      end else begin
         if (s_en) n_pcen++;
         if (s_ack) n_ack++;
         if (s_req) begin
            n_req++;
            check("req_addr", {16'h0, s_addr}, {16'h0, exp_pc});
            e.pc    = exp_pc;
            e.instr = 16'h1000 + exp_pc;
            sb.push_back(e);
            exp_pc = exp_pc + 16'd1;
         end
         if (br_s) begin
            sb.delete();
            exp_pc = br_target;
         end else if (s_valid && rdy_s) begin
            n_xfer++;
            check("xfer_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("xfer_pc", {16'h0, s_pc}, {16'h0, e.pc});
               check("xfer_instr", {16'h0, s_instr}, {16'h0, e.instr});
            end
         end
      end

      @(posedge clk);
      #1;
      if (!rst_s) pc_cur = '0;
      else if (s_en) pc_cur = s_next;
      if (!rst_s) mem_cnt = 0;
      else if (s_req) begin
         mem_cnt  = lat;
         mem_addr = s_addr;
      end else if (mem_cnt > 0) mem_cnt--;
      imem_ack   = (mem_cnt == 1);
      imem_rdata = imem_ack ? 16'h1000 + mem_addr : 16'h0;
   endtask

   initial begin
      int x0;
      reset_n    = 1'b0;
      pc_cur     = '0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      br_taken   = 1'b0;
      br_target  = '0;
      id_ready   = 1'b1;
      lat        = 1;

      // Reset and sequential fetch, L=1.
      tick();
      tick();
      check("rst_req", {31'h0, s_req}, 32'd0);
      check("rst_pc_en", {31'h0, s_en}, 32'd0);
      check("rst_pc_next", {16'h0, s_next}, 32'd0);
      check("rst_if_valid", {31'h0, s_valid}, 32'd0);
      check("rst_if_instr", {16'h0, s_instr}, 32'd0);
      check("rst_if_pc", {16'h0, s_pc}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      check("seq_requests", 32'(n_req), 32'd4);
      check("seq_pc_en_pulses", 32'(n_pcen), 32'd4);
      check("seq_acks", 32'(n_ack), 32'd4);
      check("seq_transfers", 32'(n_xfer), 32'd4);

      // Backpressure: hold the fetch of PC 4 for five cycles.
      id_ready = 1'b0;
      tick();
      tick();
      tick();
      check("bp_first_valid", {31'h0, s_valid}, 32'd1);
      x0 = n_pcen;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", {31'h0, s_valid}, 32'd1);
         check("bp_instr", {16'h0, s_instr}, 32'h1004);
         check("bp_pc", {16'h0, s_pc}, 32'h4);
         check("bp_no_req", {31'h0, s_req}, 32'd0);
      end
      check("bp_no_pc_en", 32'(n_pcen - x0), 32'd0);
      id_ready = 1'b1;
      x0 = n_xfer;
      tick();
      check("bp_release_xfer", 32'(n_xfer - x0), 32'd1);

      // Redirect in S_WAIT, L=4, two cycles after the request.
      lat = 4;
      tick();
      check("rw_req", {31'h0, s_req}, 32'd1);
      tick();
      br_taken  = 1'b1;
      br_target = 16'h0040;
      tick();
      check("rw_pc_en", {31'h0, s_en}, 32'd1);
      check("rw_pc_next", {16'h0, s_next}, 32'h40);
      br_taken = 1'b0;
      tick();
      tick();
      check("rw_stale_ack", {31'h0, s_ack}, 32'd1);
      check("rw_stale_no_pc_en", {31'h0, s_en}, 32'd0);
      tick();
      check("rw_stale_valid", {31'h0, s_valid}, 32'd0);
      check("rw_req_target", {31'h0, s_req}, 32'd1);
      check("rw_addr_target", {16'h0, s_addr}, 32'h40);
      x0 = n_xfer;
      for (int i = 0; i < 5; i++) tick();
      check("rw_xfer", 32'(n_xfer - x0), 32'd1);
      check("rw_if_pc", {16'h0, s_pc}, 32'h40);

      // Redirect coinciding with the ack, L=2.
      lat = 2;
      tick();
      tick();
      br_taken  = 1'b1;
      br_target = 16'h0080;
      tick();
      check("ra_ack", {31'h0, s_ack}, 32'd1);
      check("ra_pc_en", {31'h0, s_en}, 32'd1);
      check("ra_pc_next", {16'h0, s_next}, 32'h80);
      br_taken = 1'b0;
      tick();
      check("ra_valid", {31'h0, s_valid}, 32'd0);
      check("ra_req_target", {31'h0, s_req}, 32'd1);
      check("ra_addr_target", {16'h0, s_addr}, 32'h80);
      tick();
      tick();
      tick();
      check("ra_if_pc", {16'h0, s_pc}, 32'h80);

      // Redirect in S_HOLD with concurrent id_ready, then wrap-around.
      lat      = 1;
      id_ready = 1'b0;
      tick();
      tick();
      tick();
      check("rh_valid", {31'h0, s_valid}, 32'd1);
      check("rh_pc", {16'h0, s_pc}, 32'h81);
      id_ready  = 1'b1;
      br_taken  = 1'b1;
      br_target = 16'hFFFF;
      x0 = n_xfer;
      tick();
      check("rh_pc_next", {16'h0, s_next}, 32'hFFFF);
      check("rh_no_xfer", 32'(n_xfer - x0), 32'd0);
      br_taken = 1'b0;
      tick();
      check("rh_valid_cleared", {31'h0, s_valid}, 32'd0);
      check("rh_addr_target", {16'h0, s_addr}, 32'hFFFF);
      tick();
      check("wrap_pc_en", {31'h0, s_en}, 32'd1);
      check("wrap_pc_next", {16'h0, s_next}, 32'h0);
      tick();
      check("wrap_if_pc_hi", {16'h0, s_pc}, 32'hFFFF);
      tick();
      check("wrap_addr_zero", {16'h0, s_addr}, 32'h0);
      tick();
      tick();
      check("wrap_if_pc_lo", {16'h0, s_pc}, 32'h0);

      // Reset asserted while a read is outstanding.
      tick();
      tick();
      tick();
      check("mr_pre_pc", {16'h0, s_pc}, 32'h1);
      lat = 4;
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      check("mr_req", {31'h0, s_req}, 32'd0);
      check("mr_pc_en", {31'h0, s_en}, 32'd0);
      check("mr_pc_next", {16'h0, s_next}, 32'd0);
      tick();
      check("mr_if_valid", {31'h0, s_valid}, 32'd0);
      check("mr_if_pc", {16'h0, s_pc}, 32'd0);
      check("mr_if_instr", {16'h0, s_instr}, 32'd0);
      reset_n = 1'b1;
      lat     = 1;
      x0 = n_xfer;
      tick();
      tick();
      tick();
      check("mr_refetch_xfer", 32'(n_xfer - x0), 32'd1);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
